// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - multi-cycle signed shift-add multiplier with valid/ready handshakes
module seq_multiplier #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   prod,
  output logic [2*WIDTH-1:0] prod_full,
  output logic               ovf
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic            sign_q, sign_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0] prod_q, prod_d;
  logic [PW-1:0]   prod_full_q, prod_full_d;
  logic            ovf_q, ovf_d;

  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [PW-1:0]    fix_full;
  logic [WIDTH:0]   fix_upper;
  logic             fix_ovf;
  logic [WIDTH-1:0] fix_sat;
  logic [WIDTH-1:0] fix_prod;

  // Magnitudes of the incoming operands; the most negative value maps onto
  // 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit number.
  always_comb begin
    a_abs = a[WIDTH-1] ? (~a + {{(WIDTH-1){1'b0}}, 1'b1}) : a;
    b_abs = b[WIDTH-1] ? (~b + {{(WIDTH-1){1'b0}}, 1'b1}) : b;
  end

  // Sign fix-up of the magnitude product and narrowing to WIDTH bits; the
  // product fits WIDTH bits only when its top WIDTH+1 bits are all equal.
  always_comb begin
    fix_full  = sign_q ? (~acc_q + {{(PW-1){1'b0}}, 1'b1}) : acc_q;
    fix_upper = fix_full[PW-1:WIDTH-1];
    fix_ovf   = !((&fix_upper) || (~|fix_upper));
    fix_sat   = fix_full[PW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                               : {1'b0, {(WIDTH-1){1'b1}}};
    fix_prod  = (fix_ovf && SATURATE) ? fix_sat : fix_full[WIDTH-1:0];
  end

  // Next-state and datapath updates for the IDLE/CALC/FIX/DONE sequence.
  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    sign_d      = sign_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    prod_d      = prod_q;
    prod_full_d = prod_full_q;
    ovf_d       = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mcand_d  = {{WIDTH{1'b0}}, a_abs};
          mplier_d = b_abs;
          sign_d   = a[WIDTH-1] ^ b[WIDTH-1];
          acc_d    = '0;
          cnt_d    = CW'(WIDTH - 1);
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        // One multiplier bit per cycle; zero operands take the full count
        // so the latency never depends on the data.
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_FIX: begin
        prod_full_d = fix_full;
        ovf_d       = fix_ovf;
        prod_d      = fix_prod;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset discards any operation in flight and clears results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      sign_q      <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      prod_q      <= '0;
      prod_full_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      sign_q      <= sign_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      prod_q      <= prod_d;
      prod_full_q <= prod_full_d;
      ovf_q       <= ovf_d;
    end
  end

  // Handshake outputs come straight from the state register so neither
  // ready nor valid has a combinational path from the other side.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign prod      = prod_q;
  assign prod_full = prod_full_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - self-checking bench for seq_multiplier (saturating and wrapping instances)
`timescale 1ns/1ps
module tb_seq_multiplier;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] full;
    logic           ovf;
    logic [W-1:0]   sat;
    logic [W-1:0]   wrap;
  } vec_t;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic [W-1:0]   a_in;
  logic [W-1:0]   b_in;
  logic           out_ready;

  logic           in_ready, out_valid, ovf_s;
  logic [W-1:0]   prod_s;
  logic [2*W-1:0] prod_full_s;

  logic           in_ready_w, out_valid_w, ovf_w;
  logic [W-1:0]   prod_w;
  logic [2*W-1:0] prod_full_w;

  seq_multiplier #(.WIDTH(W), .SATURATE(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a_in), .b(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .prod(prod_s), .prod_full(prod_full_s), .ovf(ovf_s)
  );

  seq_multiplier #(.WIDTH(W), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .a(a_in), .b(b_in), .out_valid(out_valid_w), .out_ready(out_ready),
    .prod(prod_w), .prod_full(prod_full_w), .ovf(ovf_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   accepted = 0;
  bit   ov_prev = 0;
  vec_t cur_exp;
  vec_t exp_q[$];
  int   rises[$];
  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    vec_t r;
    int   ai, bi, p;
    ai = int'($signed(a));
    bi = int'($signed(b));
    p  = ai * bi;
    r.a    = a;
    r.b    = b;
    r.full = p[15:0];
    r.ovf  = (p > 127) || (p < -128);
    r.wrap = p[7:0];
    r.sat  = r.ovf ? ((p > 0) ? 8'h7F : 8'h80) : p[7:0];
    return r;
  endfunction

  // Scoreboard hook evaluated just before each rising edge with the values
  // that edge will sample.
  task automatic sample_pre();
    vec_t e;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && !ov_prev) rises.push_back(cyc);
      if (exp_q.size() > 0) chk("in_ready_busy", in_ready, 0);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          fail_now("spurious_out_valid");
        end else if (out_ready) begin
          e = exp_q.pop_front();
          chk("prod_full", prod_full_s, e.full);
          chk("prod_sat", prod_s, e.sat);
          chk("ovf", ovf_s, e.ovf);
          chk("prod_wrap", prod_w, e.wrap);
          chk("prod_full_wrap", prod_full_w, e.full);
          chk("ovf_wrap", ovf_w, e.ovf);
          chk("out_valid_wrap", out_valid_w, 1);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(cur_exp);
        acc_cyc  = cyc;
        accepted = 1;
      end
    end
    ov_prev = out_valid;
  endtask

  task automatic step();
    sample_pre();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic accept_one(input logic [W-1:0] a, input logic [W-1:0] b, input vec_t e);
    cur_exp  = e;
    a_in     = a;
    b_in     = b;
    in_valid = 1'b1;
    accepted = 0;
    for (int i = 0; i < 30 && !accepted; i++) step();
    if (!accepted) fail_now("accept_timeout");
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) step();
    if (exp_q.size() > 0) begin
      fail_now("result_timeout");
      exp_q.delete();
    end
  endtask

  task automatic run_vec(input logic [W-1:0] a, input logic [W-1:0] b, input vec_t e);
    int n;
    n = rises.size();
    accept_one(a, b, e);
    in_valid = 1'b0;
    drain();
    if (rises.size() > n) chk("latency", rises[$] - acc_cyc, 10);
    else fail_now("no_out_valid");
  endtask

  logic [W-1:0]   snap_prod;
  logic [2*W-1:0] snap_full;
  logic           snap_ovf;
  int             base;

  initial begin
    tbl[0]  = '{8'd5,   8'hFD, 16'hFFF1, 1'b0, 8'hF1, 8'hF1};
    tbl[1]  = '{8'd16,  8'd16, 16'h0100, 1'b1, 8'h7F, 8'h00};
    tbl[2]  = '{8'h80,  8'h80, 16'h4000, 1'b1, 8'h7F, 8'h00};
    tbl[3]  = '{8'h80,  8'd1,  16'hFF80, 1'b0, 8'h80, 8'h80};
    tbl[4]  = '{8'hF0,  8'd9,  16'hFF70, 1'b1, 8'h80, 8'h70};
    tbl[5]  = '{8'd7,   8'd7,  16'h0031, 1'b0, 8'h31, 8'h31};
    tbl[6]  = '{8'd0,   8'hB3, 16'h0000, 1'b0, 8'h00, 8'h00};
    tbl[7]  = '{8'hFF,  8'hFF, 16'h0001, 1'b0, 8'h01, 8'h01};
    tbl[8]  = '{8'h7F,  8'h7F, 16'h3F01, 1'b1, 8'h7F, 8'h01};
    tbl[9]  = '{8'h7F,  8'h80, 16'hC080, 1'b1, 8'h80, 8'h80};
    tbl[10] = '{8'h80,  8'h7F, 16'hC080, 1'b1, 8'h80, 8'h80};
    tbl[11] = '{8'hF8,  8'd16, 16'hFF80, 1'b0, 8'h80, 8'h80};
    tbl[12] = '{8'd8,   8'd16, 16'h0080, 1'b1, 8'h7F, 8'h80};
    tbl[13] = '{8'hFF,  8'h80, 16'h0080, 1'b1, 8'h7F, 8'h80};

    rst = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0; out_ready = 1'b1;
    cur_exp = tbl[0];
    @(negedge clk);
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_prod", prod_s, 0);
    chk("rst_prod_full", prod_full_s, 0);
    chk("rst_ovf", ovf_s, 0);

    // Table-driven vectors, one operation at a time.
    for (int i = 0; i < 14; i++) run_vec(tbl[i].a, tbl[i].b, tbl[i]);

    // Random operands against the arithmetic model.
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      run_vec(ra, rb, model(ra, rb));
    end

    // Backpressure: result held five cycles, in_valid pulses ignored.
    out_ready = 1'b0;
    accept_one(8'hF0, 8'd9, tbl[4]);
    in_valid = 1'b0;
    for (int i = 0; i < 30 && !out_valid; i++) step();
    chk("bp_out_valid_rise", out_valid, 1);
    snap_prod = prod_s; snap_full = prod_full_s; snap_ovf = ovf_s;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      a_in = 8'd1; b_in = 8'd1;
      cur_exp = model(8'd1, 8'd1);
      step();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_prod", prod_s, snap_prod);
      chk("bp_prod_full", prod_full_s, snap_full);
      chk("bp_ovf", ovf_s, snap_ovf);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_idle_in_ready", in_ready, 1);
    chk("bp_idle_out_valid", out_valid, 0);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Reset on the fourth CALC cycle discards the operation.
    accept_one(8'd3, 8'd5, model(8'd3, 8'd5));
    in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_prod", prod_s, 0);
    chk("mid_rst_prod_full", prod_full_s, 0);
    chk("mid_rst_ovf", ovf_s, 0);
    run_vec(8'd7, 8'd7, tbl[5]);

    // Back-to-back with in_valid held high.
    base = rises.size();
    accept_one(8'd0, 8'hB3, tbl[6]);
    accept_one(8'hFF, 8'hFF, tbl[7]);
    accept_one(8'h7F, 8'h7F, tbl[8]);
    in_valid = 1'b0;
    drain();
    if (rises.size() == base + 3) begin
      chk("b2b_spacing_1", rises[base+1] - rises[base], 11);
      chk("b2b_spacing_2", rises[base+2] - rises[base+1], 11);
    end else begin
      fail_now("b2b_result_count");
    end

    step(); step();
    chk("final_idle", in_ready, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Multi-cycle, parametrised signed shift-add multiplier.
- Successor to the 8-bit combinational multiplier in the matrix coprocessor datapath.
- Generalised operand width, valid/ready handshakes on both sides, a full-width product, a correct overflow flag, and selectable saturate/wrap narrowing.
- Processes one multiplier bit per clock so the MAC lanes of the matrix engine can share a small, timing-friendly unit.

Parameters:
- WIDTH, 8, operand and narrowed-result width in bits (two's complement), minimum 2.
- SATURATE, 1, 1 = clamp narrowed result on overflow; 0 = wrap (keep low WIDTH bits).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operands a/b valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  signed multiplicand.
- b  in  WIDTH  signed multiplier.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- prod  out  WIDTH  signed narrowed product (saturated or wrapped per SATURATE).
- prod_full  out  2*WIDTH  signed exact product.
- ovf  out  1  exact product outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].

Behaviour:
- Reset (rst=1 at a rising edge), regardless of state:
  - State goes to IDLE.
  - in_ready=1, out_valid=0, prod=0, prod_full=0, ovf=0.
  - Counter and accumulator are cleared; any in-flight operation is discarded, never delivered.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register |a| and |b| as WIDTH-bit unsigned values (|-2^(WIDTH-1)| = 2^(WIDTH-1), which fits unsigned).
  - Register sign = a[WIDTH-1]^b[WIDTH-1].
  - Clear the 2*WIDTH-bit accumulator, load bit counter = WIDTH-1, go to CALC.
- CALC:
  - in_ready=0.
  - Each cycle, if the current LSB of |b| is 1, add the current shifted |a| to the accumulator; then shift |a| left by 1 and |b| right by 1.
  - After exactly WIDTH cycles (counter reaches 0), go to FIX.
  - Zero operands are not short-circuited; latency is constant.
- FIX (1 cycle):
  - prod_full = sign ? -acc : acc, computed in 2*WIDTH bits.
  - ovf = 1 iff prod_full > 2^(WIDTH-1)-1 or prod_full < -2^(WIDTH-1).
  - prod = prod_full[WIDTH-1:0] if ovf=0.
  - If ovf=1 and SATURATE=1: prod = 2^(WIDTH-1)-1 when prod_full is positive, -2^(WIDTH-1) when negative.
  - If ovf=1 and SATURATE=0: prod = prod_full[WIDTH-1:0].
  - Go to DONE.
- DONE:
  - out_valid=1; prod, prod_full and ovf stay stable while out_valid=1 and out_ready=0.
  - On out_ready=1, out_valid drops at the next edge and state returns to IDLE.
- Latency and throughput:
  - Accept edge at cycle 0 gives out_valid=1 after the edge at cycle WIDTH+2 (10 cycles for WIDTH=8).
  - With out_ready held at 1, throughput is one result per WIDTH+3 cycles.
- Outputs after the handshake: prod/prod_full/ovf hold their last values in IDLE and CALC until the next FIX.
- in_valid is ignored outside IDLE, so operands cannot be overwritten mid-operation.
- out_ready is ignored outside DONE.
- Simultaneous rst with in_valid or out_ready: reset wins; nothing is accepted or delivered.
- No combinational path from in_valid to in_ready or from out_ready to out_valid.

Test Plan:
- WIDTH=8, SATURATE=1, a=5, b=-3, out_ready=1:
  - Result: prod=-15 (0xF1), prod_full=-15 (0xFFF1), ovf=0.
  - out_valid rises exactly 10 cycles after accept, and in_ready=0 throughout.
- a=16, b=16:
  - SATURATE=1: prod_full=256, ovf=1, prod=127 (0x7F).
  - SATURATE=0 instance: prod=0x00, ovf=1.
- Width-extreme operands:
  - a=-128, b=-128: prod_full=16384, ovf=1, prod=127.
  - a=-128, b=1: prod=-128, ovf=0.
  - a=-16, b=9: prod_full=-144, ovf=1, prod=-128.
- Backpressure: hold out_ready=0 for 5 cycles in DONE.
  - out_valid stays 1; prod/prod_full/ovf stay stable; in_ready stays 0; in_valid pulses are ignored.
  - Raising out_ready gives IDLE the next cycle.
- Reset mid-op: assert rst for one cycle on the 4th CALC cycle.
  - Next cycle: in_ready=1, out_valid=0, prod=0, ovf=0.
  - A new a=7, b=7 then completes with prod=49, ovf=0, at the normal 10-cycle latency.
- Back-to-back with out_ready=1: feed a=0,b=-77 then a=-1,b=-1 then a=127,b=127 (in_valid always high).
  - Results in order: (0, ovf=0), (1, ovf=0), (127 saturated with prod_full=16129, ovf=1), spaced 11 cycles apart.
